uart_cmd_sequencer: RTL

Command sequencer between the UART byte receiver and the APB master. Parses the received byte stream into fixed-format command frames (header, command, address, optional data) and issues one APB read or write request per valid frame. Returns a single response byte to the UART transmitter. Malformed frames, unknown commands and stalled frames are discarded with an error pulse.

---
 rtl/uart_cmd_sequencer_if.sv | 35 +++
 rtl/uart_cmd_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-stream, APB request and UART response signals of the command sequencer.
// master is the sequencer side, slave is the UART/APB environment side.
interface uart_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       apb_req;
  logic       apb_write;
  logic [7:0] apb_addr;
  logic [7:0] apb_wdata;
  logic       apb_done;
  logic [7:0] apb_rdata;
  logic       apb_err;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_err;

  modport master (
    input  rx_data, rx_valid,
    output apb_req, apb_write, apb_addr, apb_wdata,
    input  apb_done, apb_rdata, apb_err,
    output tx_data, tx_start,
    input  tx_busy,
    output frame_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  apb_req, apb_write, apb_addr, apb_wdata,
    output apb_done, apb_rdata, apb_err,
    input  tx_data, tx_start,
    output tx_busy,
    input  frame_err
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Parses UART command frames (hdr, cmd, addr[, data]) into single APB
// transfers and returns one response byte per frame.
module uart_cmd_sequencer #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter logic [7:0] CMD_WR         = 8'h01,
  parameter logic [7:0] CMD_RD         = 8'h02,
  parameter int         TIMEOUT_CYCLES = 17360,
  parameter logic [7:0] ERR_BYTE       = 8'hEE,
  parameter logic [7:0] OK_BYTE        = 8'h00
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_sequencer_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, ISSUE, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          apb_req_q, apb_req_d;
  logic          apb_write_q, apb_write_d;
  logic [7:0]    apb_addr_q, apb_addr_d;
  logic [7:0]    apb_wdata_q, apb_wdata_d;
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          frame_err_q, frame_err_d;

  logic in_frame;
  logic expired;

  assign in_frame = (state_q == CMD) || (state_q == ADDR) ||
                    (state_q == DATA);
  assign expired  = (cnt_q == TMAX);

  always_comb begin
    state_d     = state_q;
    apb_req_d   = apb_req_q;
    apb_write_d = apb_write_q;
    apb_addr_d  = apb_addr_q;
    apb_wdata_d = apb_wdata_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;

    // Inter-byte gap counter; leaving the frame on expiry keeps it from wrapping
    if (in_frame && !bus.rx_valid && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HEADER) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
            apb_write_d = (bus.rx_data == CMD_WR);
            state_d     = ADDR;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ADDR: begin
        if (bus.rx_valid) begin
          apb_addr_d = bus.rx_data;
          state_d    = apb_write_q ? DATA : ISSUE;
          apb_req_d  = !apb_write_q;
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          apb_wdata_d = bus.rx_data;
          state_d     = ISSUE;
          apb_req_d   = 1'b1;
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      ISSUE: begin
        if (bus.apb_done) begin
          apb_req_d = 1'b0;
          state_d   = RESP;
          if (bus.apb_err) begin
            resp_d = ERR_BYTE;
          end else if (apb_write_q) begin
            resp_d = OK_BYTE;
          end else begin
            resp_d = bus.apb_rdata;
          end
        end
      end
      RESP: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        apb_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      apb_req_q   <= 1'b0;
      apb_write_q <= 1'b0;
      apb_addr_q  <= 8'h00;
      apb_wdata_q <= 8'h00;
      resp_q      <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      apb_req_q   <= apb_req_d;
      apb_write_q <= apb_write_d;
      apb_addr_q  <= apb_addr_d;
      apb_wdata_q <= apb_wdata_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.apb_req   = apb_req_q;
  assign bus.apb_write = apb_write_q;
  assign bus.apb_addr  = apb_addr_q;
  assign bus.apb_wdata = apb_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.frame_err = frame_err_q;

endmodule
